// File: rtl/glitch_pkg.sv
// Shared types and reset defaults for the glitch sequencer.
package glitch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StPulse,
    StGap
  } ch_state_e;

  typedef enum logic [1:0] {
    FieldOffset = 2'd0,
    FieldWidth  = 2'd1,
    FieldRepeat = 2'd2,
    FieldGap    = 2'd3
  } cfg_field_e;

  localparam int unsigned OffsetRst = 0;
  localparam int unsigned WidthRst  = 0;
  localparam int unsigned RepeatRst = 1;
  localparam int unsigned GapRst    = 1;

endpackage

// File: rtl/glitch_channel.sv
// One fault channel: config registers, burst FSM and registered fault output.
module glitch_channel
  import glitch_pkg::*;
#(
  parameter int unsigned CntW = 16,
  parameter int unsigned RepW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_we_i,
  input  logic [1:0]      cfg_field_i,
  input  logic [CntW-1:0] cfg_wdata_i,
  input  logic            arm_i,
  input  logic            abort_i,
  input  logic            trig_i,
  input  logic            continuous_i,
  output logic            fault_o,
  output logic            idle_o,
  output logic            armed_o,
  output logic            active_o,
  output logic            active_nxt_o
);

  logic [CntW-1:0] offset_q, width_q, gap_q;
  logic [RepW-1:0] repeat_q;
  ch_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RepW-1:0] rep_q, rep_d;
  logic            fault_q, fault_d;

  // Zero repeat and zero gap both behave as one.
  logic [CntW-1:0] gap_m1;
  logic [RepW-1:0] rep_eff;
  ch_state_e       rest_state;

  assign gap_m1     = (gap_q == '0) ? '0 : gap_q - CntW'(1);
  assign rep_eff    = (repeat_q == '0) ? RepW'(1) : repeat_q;
  assign rest_state = continuous_i ? StArmed : StIdle;

  // Configuration registers; the top only strobes us when the write is legal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q <= CntW'(OffsetRst);
      width_q  <= CntW'(WidthRst);
      repeat_q <= RepW'(RepeatRst);
      gap_q    <= CntW'(GapRst);
    end else if (cfg_we_i) begin
      unique case (cfg_field_e'(cfg_field_i))
        FieldOffset: offset_q <= cfg_wdata_i;
        FieldWidth:  width_q  <= cfg_wdata_i;
        FieldRepeat: repeat_q <= cfg_wdata_i[RepW-1:0];
        FieldGap:    gap_q    <= cfg_wdata_i;
      endcase
    end
  end

  // Burst state, counters and the fault flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rep_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic; fault_d is set one cycle ahead so fault_o is a pure flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    fault_d = fault_q;
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      rep_d   = '0;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm_i) state_d = StArmed;
        end
        StArmed: begin
          if (trig_i) begin
            rep_d = rep_eff;
            if (width_q == '0) begin
              state_d = rest_state;
            end else if (offset_q == '0) begin
              state_d = StPulse;
              cnt_d   = width_q - CntW'(1);
              fault_d = 1'b1;
            end else begin
              state_d = StDelay;
              cnt_d   = offset_q - CntW'(1);
            end
          end
        end
        StDelay, StGap: begin
          if (cnt_q == '0) begin
            state_d = StPulse;
            cnt_d   = width_q - CntW'(1);
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            fault_d = 1'b0;
            if (rep_q <= RepW'(1)) begin
              state_d = rest_state;
              rep_d   = '0;
            end else begin
              state_d = StGap;
              rep_d   = rep_q - RepW'(1);
              cnt_d   = gap_m1;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign fault_o      = fault_q;
  assign idle_o       = (state_q == StIdle);
  assign armed_o      = (state_q == StArmed);
  assign active_o     = (state_q inside {StDelay, StPulse, StGap});
  assign active_nxt_o = (state_d inside {StDelay, StPulse, StGap});

endmodule

// File: rtl/glitch_sequencer.sv
// Multi-channel glitch sequencer: trigger sync, cfg decode, channel array, status.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REP_W  = 8,
  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger_in,
  input  logic              cfg_we,
  input  logic [ChW-1:0]    cfg_ch,
  input  logic [1:0]        cfg_field,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              arm,
  input  logic              abort,
  input  logic              continuous,
  output logic [NUM_CH-1:0] fault_out,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              trig_missed
);

  logic sync1_q, sync2_q, sync3_q, trig_pulse_q;
  logic done_q, cfg_err_q, trig_missed_q, burst_q;

  logic [NUM_CH-1:0] idle, armed, active, active_nxt, ch_we;
  logic ch_valid, cfg_bad, arm_go, trig_accept, done_d;

  // Two-flop synchronizer plus registered rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      trig_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= trigger_in;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      trig_pulse_q <= sync2_q & ~sync3_q;
    end
  end

  // A power-of-two channel count makes every cfg_ch encoding valid.
  if (NUM_CH == (1 << ChW)) begin : g_ch_full
    assign ch_valid = 1'b1;
  end else begin : g_ch_part
    assign ch_valid = (cfg_ch < ChW'(NUM_CH));
  end

  assign busy    = ~&idle;
  assign cfg_bad = cfg_we & (busy | ~ch_valid);
  assign arm_go  = arm & ~abort & ~busy;
  // Start only from a quiescent array with something armed.
  assign trig_accept = trig_pulse_q & ~abort & (|armed) & ~(|active);
  // Done fires when the last armed channel leaves the burst states.
  assign done_d = (burst_q | trig_accept) & ~abort & ~(|active_nxt);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_we[c] = cfg_we & ~cfg_bad & (cfg_ch == ChW'(c));

    glitch_channel #(
      .CntW (CNT_W),
      .RepW (REP_W)
    ) u_channel (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cfg_we_i     (ch_we[c]),
      .cfg_field_i  (cfg_field),
      .cfg_wdata_i  (cfg_wdata),
      .arm_i        (arm_go),
      .abort_i      (abort),
      .trig_i       (trig_accept),
      .continuous_i (continuous),
      .fault_o      (fault_out[c]),
      .idle_o       (idle[c]),
      .armed_o      (armed[c]),
      .active_o     (active[c]),
      .active_nxt_o (active_nxt[c])
    );
  end

  // Status pulses and the burst-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      trig_missed_q <= 1'b0;
      burst_q       <= 1'b0;
    end else begin
      done_q        <= done_d;
      cfg_err_q     <= cfg_bad;
      trig_missed_q <= trig_pulse_q & ~abort & ~trig_accept;
      burst_q       <= (abort | done_d) ? 1'b0 : (burst_q | trig_accept);
    end
  end

  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign trig_missed = trig_missed_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: tabulated waveform points per scenario.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger_in;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_wdata;
  logic        arm;
  logic        abort;
  logic        continuous;
  logic [3:0]  fault_out;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        trig_missed;

  glitch_sequencer #(
    .NUM_CH (4),
    .CNT_W  (16),
    .REP_W  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_in  (trigger_in),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_field   (cfg_field),
    .cfg_wdata   (cfg_wdata),
    .arm         (arm),
    .abort       (abort),
    .continuous  (continuous),
    .fault_out   (fault_out),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .trig_missed (trig_missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scen;
    int         k;
    logic [3:0] fault;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt, err_cnt, miss_cnt, err_k, miss_k;

  function automatic void add(input int s, input int k, input logic [3:0] f,
                              input logic b, input logic d);
    vec_t v;
    v.scen = s; v.k = k; v.fault = f; v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  // O=20 W=10 R=3 G=5 on ch0, other channels width 0.
  function automatic void add_burst1(input int s, input logic cont);
    add(s, 0, 4'b0000, 1'b1, 1'b0);
    add(s, 3, 4'b0000, 1'b1, 1'b0);
    add(s, 22, 4'b0000, 1'b1, 1'b0);
    add(s, 23, 4'b0001, 1'b1, 1'b0);
    add(s, 32, 4'b0001, 1'b1, 1'b0);
    add(s, 33, 4'b0000, 1'b1, 1'b0);
    add(s, 37, 4'b0000, 1'b1, 1'b0);
    add(s, 38, 4'b0001, 1'b1, 1'b0);
    add(s, 47, 4'b0001, 1'b1, 1'b0);
    add(s, 48, 4'b0000, 1'b1, 1'b0);
    add(s, 52, 4'b0000, 1'b1, 1'b0);
    add(s, 53, 4'b0001, 1'b1, 1'b0);
    add(s, 62, 4'b0001, 1'b1, 1'b0);
    add(s, 63, 4'b0000, cont, 1'b1);
    add(s, 64, 4'b0000, cont, 1'b0);
  endfunction

  task automatic check(input string name, input int k, input logic [3:0] ef,
                       input logic eb, input logic ed);
    n_vec++;
    if (fault_out !== ef || busy !== eb || done !== ed) begin
      n_err++;
      $display("FAIL %s k=%0d: fault_out=%b busy=%b done=%b, expected %b %b %b",
               name, k, fault_out, busy, done, ef, eb, ed);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] f, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_field = f; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  // Raise trigger so the next rising edge is t0, then walk cycles t0+k.
  task automatic run(input int scen, input int last_k);
    done_cnt = 0; err_cnt = 0; miss_cnt = 0; err_k = -1; miss_k = -1;
    @(negedge clk);
    trigger_in = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (cfg_err) begin err_cnt++; err_k = k; end
      if (trig_missed) begin miss_cnt++; miss_k = k; end
      foreach (vecs[i])
        if (vecs[i].scen == scen && vecs[i].k == k)
          check($sformatf("scen%0d", scen), k, vecs[i].fault, vecs[i].busy, vecs[i].done);
      if (k == 5) trigger_in = 1'b0;
      if (scen == 3 && k == 30) abort = 1'b1;
      if (scen == 3 && k == 31) abort = 1'b0;
      if (scen == 4) begin
        if (k == 10) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_field = 2'd1; cfg_wdata = 16'd2; end
        if (k == 11) cfg_we = 1'b0;
        if (k == 40) trigger_in = 1'b1;
        if (k == 45) trigger_in = 1'b0;
      end
      if (scen == 6 && k == 25) begin
        rst_n = 1'b0;
        #1;
        check("async_reset", k, 4'b0000, 1'b0, 1'b0);
        check_val("async_reset_cfg_err", int'(cfg_err), 0);
        check_val("async_reset_trig_missed", int'(trig_missed), 0);
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    add_burst1(1, 1'b0);
    add(2, 2, 4'b0000, 1'b1, 1'b0);
    add(2, 3, 4'b0001, 1'b1, 1'b0);
    add(2, 4, 4'b0000, 1'b1, 1'b0);
    add(2, 6, 4'b0000, 1'b1, 1'b0);
    add(2, 7, 4'b0010, 1'b1, 1'b0);
    add(2, 8, 4'b0010, 1'b1, 1'b0);
    add(2, 9, 4'b0000, 1'b0, 1'b1);
    add(2, 10, 4'b0000, 1'b0, 1'b0);
    add(3, 29, 4'b0001, 1'b1, 1'b0);
    add(3, 30, 4'b0001, 1'b1, 1'b0);
    add(3, 31, 4'b0000, 1'b0, 1'b0);
    add(3, 40, 4'b0000, 1'b0, 1'b0);
    add(3, 63, 4'b0000, 1'b0, 1'b0);
    add_burst1(4, 1'b0);
    add_burst1(5, 1'b1);
    add(5, 150, 4'b0000, 1'b1, 1'b0);
    add(6, 23, 4'b0001, 1'b1, 1'b0);
    add(7, 2, 4'b0000, 1'b1, 1'b0);
    add(7, 3, 4'b0001, 1'b1, 1'b0);
    add(7, 5, 4'b0001, 1'b1, 1'b0);
    add(7, 6, 4'b0000, 1'b0, 1'b1);
    add(7, 11, 4'b0000, 1'b0, 1'b0);

    rst_n = 1'b0; trigger_in = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_field = 2'd0;
    cfg_wdata = 16'd0; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 0, 4'b0000, 1'b0, 1'b0);
    check_val("reset_cfg_err", int'(cfg_err), 0);
    check_val("reset_trig_missed", int'(trig_missed), 0);
    rst_n = 1'b1;

    // Trigger with every channel idle is reported as missed.
    miss_cnt = 0;
    @(negedge clk); trigger_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) trigger_in = 1'b0;
      if (trig_missed) miss_cnt++;
    end
    check_val("idle_trig_missed", miss_cnt, 1);

    // Three-pulse burst on ch0.
    cfg_write(2'd0, 2'd0, 16'd20);
    cfg_write(2'd0, 2'd1, 16'd10);
    cfg_write(2'd0, 2'd2, 16'd3);
    cfg_write(2'd0, 2'd3, 16'd5);
    pulse_arm();
    run(1, 70);

    // Zero offset on ch0 alongside a delayed ch1.
    cfg_write(2'd0, 2'd0, 16'd0);
    cfg_write(2'd0, 2'd1, 16'd1);
    cfg_write(2'd0, 2'd2, 16'd1);
    cfg_write(2'd1, 2'd0, 16'd4);
    cfg_write(2'd1, 2'd1, 16'd2);
    cfg_write(2'd1, 2'd2, 16'd1);
    pulse_arm();
    run(2, 12);

    // Abort in the middle of the first pulse.
    cfg_write(2'd0, 2'd0, 16'd20);
    cfg_write(2'd0, 2'd1, 16'd10);
    cfg_write(2'd0, 2'd2, 16'd3);
    cfg_write(2'd1, 2'd1, 16'd0);
    pulse_arm();
    run(3, 70);
    check_val("abort_no_done", done_cnt, 0);

    // Write and retrigger during a burst are both rejected.
    pulse_arm();
    run(4, 70);
    check_val("busy_write_cfg_err_count", err_cnt, 1);
    check_val("busy_write_cfg_err_cycle", err_k, 11);
    check_val("retrig_missed_count", miss_cnt, 1);
    check_val("retrig_missed_cycle", miss_k, 44);
    pulse_arm();
    run(1, 70);

    // Continuous mode: two triggers 200 cycles apart, single arm.
    continuous = 1'b1;
    pulse_arm();
    run(5, 198);
    check_val("cont_done_first", done_cnt, 1);
    run(5, 70);
    check_val("cont_done_second", done_cnt, 1);
    check_val("cont_busy_held", int'(busy), 1);
    continuous = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_val("abort_from_armed_busy", int'(busy), 0);

    // Reset mid-pulse, then confirm config defaults by a width-only burst.
    pulse_arm();
    run(6, 70);
    @(negedge clk); rst_n = 1'b1;
    cfg_write(2'd0, 2'd1, 16'd3);
    pulse_arm();
    run(7, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent fault output channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16: width of the offset, width and gap counters.
REQ-003 SHALL have parameter REP_W, default 8: width of the repeat counter.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port trigger_in, input, 1: asynchronous target trigger, active on its rising edge.
REQ-007 SHALL have port cfg_we, input, 1: configuration write strobe, one cycle.
REQ-008 SHALL have port cfg_ch, input, $clog2(NUM_CH) (min 1): target channel of the write.
REQ-009 SHALL have port cfg_field, input, 2: 0 = offset, 1 = width, 2 = repeat, 3 = gap.
REQ-010 SHALL have port cfg_wdata, input, CNT_W: write data; repeat uses the low REP_W bits.
REQ-011 SHALL have port arm, input, 1: one-cycle pulse that arms all channels.
REQ-012 SHALL have port abort, input, 1: one-cycle pulse that returns all channels to IDLE.
REQ-013 SHALL have port continuous, input, 1: 1 = re-arm automatically after each burst.
REQ-014 SHALL have port fault_out, output, NUM_CH: glitch pulse per channel, active high.
REQ-015 SHALL have port busy, output, 1: high when any channel is not IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a burst completes on all channels.
REQ-017 SHALL have port cfg_err, output, 1: one-cycle pulse when a write is rejected.
REQ-018 SHALL have port trig_missed, output, 1: one-cycle pulse when a trigger edge arrives outside ARMED.

Function
REQ-019 trigger_in SHALL pass through a 2-FF synchronizer and a rising-edge detector; if trigger_in is first sampled high at edge t0, trig_pulse SHALL be high in cycle t0+2.
REQ-020 Each channel SHALL implement the FSM IDLE -> ARMED (arm) -> DELAY (trig_pulse) -> PULSE -> GAP -> PULSE ... -> IDLE.
REQ-021 With offset O, width W, gap G and repeat R, fault_out[c] SHALL be high in cycles t0+3+O .. t0+2+O+W for the first pulse.
REQ-022 Each later pulse SHALL start G cycles after the previous one falls; R pulses SHALL be issued in total.
REQ-023 Boundary values: O = 0 is legal (zero added delay); R = 0 SHALL be treated as 1; G = 0 SHALL be treated as 1.
REQ-024 A channel with W = 0 SHALL never assert fault_out and SHALL go to IDLE in the cycle after trig_pulse.
REQ-025 done SHALL pulse in the first cycle in which all channels armed by the same arm are back in IDLE after a trigger.
REQ-026 When continuous = 1, done SHALL coincide with all channels re-entering ARMED instead of IDLE.
REQ-027 A write while busy = 1 SHALL be ignored and SHALL pulse cfg_err in the next cycle.
REQ-028 A write with cfg_ch >= NUM_CH SHALL be ignored and SHALL pulse cfg_err in the next cycle.
REQ-029 arm while busy = 1 SHALL be ignored.
REQ-030 A trig_pulse while any channel is in DELAY, PULSE or GAP SHALL be ignored and SHALL pulse trig_missed.
REQ-031 A trig_pulse while all channels are in IDLE SHALL be ignored and SHALL pulse trig_missed.
REQ-032 abort SHALL have priority over arm and trig_pulse in the same cycle.
REQ-033 After abort, fault_out and busy SHALL be 0 from the next cycle, and done SHALL NOT pulse.
REQ-034 fault_out SHALL be driven directly from registers (glitch-free, no combinational output path).

Reset
REQ-035 On rst_n low, all channels SHALL be IDLE and the synchronizer SHALL be cleared.
REQ-036 On rst_n low, fault_out, busy, done, cfg_err and trig_missed SHALL be 0.
REQ-037 On rst_n low, the config registers SHALL reset to offset = 0, width = 0, repeat = 1, gap = 1.
REQ-038 Reset asserted mid-burst SHALL force fault_out low asynchronously, without waiting for a clock edge.

Structure
REQ-039 Package glitch_pkg SHALL hold the channel state enum, the cfg_field codes and the config reset defaults.
REQ-040 Per-channel FSM, counters and config registers SHALL be a sub-module glitch_channel, instantiated NUM_CH times by generate.
REQ-041 The synchronizer, cfg write decode and done/busy aggregation SHALL reside in glitch_sequencer.

Verification
REQ-042 Bench SHALL cover: ch0 O=20 W=10 R=3 G=5, arm, trigger at t0 -> fault_out[0] high t0+23..32, t0+38..47, t0+53..62; done at t0+63.
REQ-043 Bench SHALL cover: ch0 O=0 W=1, ch1 O=4 W=2, both R=1 -> fault_out[0] high t0+3; fault_out[1] high t0+7..8; done at t0+9.
REQ-044 Bench SHALL cover: abort at t0+30 in the first scenario -> fault_out = 0 from t0+31; busy = 0 from t0+31; no done pulse.
REQ-045 Bench SHALL cover: a cfg write during a burst, and a second trigger during a burst -> cfg_err pulses once; trig_missed pulses once; config unchanged.
REQ-046 Bench SHALL cover: continuous = 1 with two triggers 200 cycles apart -> two identical bursts with no second arm; busy stays 1.
REQ-047 Bench SHALL cover: rst_n low at t0+25 -> fault_out low immediately; all outputs 0; config returns to reset defaults.
